// File: rtl/lift_car_ctrl.sv
// lift_car_ctrl: car motion/door sequencer timed by the divided slow_clk.
// Ports: clk, reset (async, high), slow_clk, call_req[FLOORS] in;
//        cur_floor, dir_up, moving, door_open, pending[FLOORS] out.
module lift_car_ctrl #(
  parameter int FLOORS       = 4,
  parameter int FLOOR_W      = $clog2(FLOORS),
  parameter int TRAVEL_TICKS = 3,
  parameter int DOOR_TICKS   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               slow_clk,
  input  logic [FLOORS-1:0]  call_req,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               dir_up,
  output logic               moving,
  output logic               door_open,
  output logic [FLOORS-1:0]  pending
);

  localparam int TW = $clog2(TRAVEL_TICKS) + 1;
  localparam int DW = $clog2(DOOR_TICKS) + 1;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DOOR
  } state_t;

  state_t             state, state_n;
  logic [FLOOR_W-1:0] floor_n, nf;
  logic               dir_n;
  logic [TW-1:0]      tcnt, tcnt_n;
  logic [DW-1:0]      dcnt, dcnt_n;
  logic [FLOORS-1:0]  pend_n, clr;
  logic [FLOORS-1:0]  up_cur, dn_cur;
  logic [FLOORS-1:0]  up_nf, dn_nf;
  logic               ahead_cur, back_cur;
  logic               ahead_nf;
  logic               slow_clk_d, tick;

  assign tick = slow_clk & ~slow_clk_d;

  // Floor the car reaches on the next step
  assign nf = dir_up ? cur_floor + FLOOR_W'(1)
                     : cur_floor - FLOOR_W'(1);

  always_comb begin
    up_cur = '0;
    dn_cur = '0;
    up_nf  = '0;
    dn_nf  = '0;
    for (int i = 0; i < FLOORS; i++) begin
      up_cur[i] = pending[i] & (FLOOR_W'(i) > cur_floor);
      dn_cur[i] = pending[i] & (FLOOR_W'(i) < cur_floor);
      up_nf[i]  = pending[i] & (FLOOR_W'(i) > nf);
      dn_nf[i]  = pending[i] & (FLOOR_W'(i) < nf);
    end
  end

  assign ahead_cur = dir_up ? |up_cur : |dn_cur;
  assign back_cur  = dir_up ? |dn_cur : |up_cur;
  assign ahead_nf  = dir_up ? |up_nf : |dn_nf;

  always_comb begin
    state_n = state;
    floor_n = cur_floor;
    dir_n   = dir_up;
    tcnt_n  = tcnt;
    dcnt_n  = dcnt;
    clr     = '0;
    unique case (state)
      IDLE: begin
        if (pending[cur_floor]) begin
          state_n        = DOOR;
          clr[cur_floor] = 1'b1;
        end else if (ahead_cur) begin
          state_n = MOVE;
        end else if (back_cur) begin
          state_n = MOVE;
          dir_n   = ~dir_up;
        end
      end
      MOVE: begin
        if (tick) begin
          if (tcnt == TW'(TRAVEL_TICKS - 1)) begin
            floor_n = nf;
            tcnt_n  = '0;
            if (pending[nf]) begin
              state_n = DOOR;
              clr[nf] = 1'b1;
            end else if (!ahead_nf) begin
              state_n = IDLE;
            end
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
      end
      DOOR: begin
        // Calls for the floor we are serving are absorbed
        clr[cur_floor] = 1'b1;
        if (tick) begin
          if (dcnt == DW'(DOOR_TICKS - 1)) begin
            state_n = IDLE;
          end else begin
            dcnt_n = dcnt + DW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Counters restart on every state entry
    if (state_n != state) begin
      tcnt_n = '0;
      dcnt_n = '0;
    end
    pend_n = (pending | call_req) & ~clr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_floor  <= '0;
      dir_up     <= 1'b1;
      tcnt       <= '0;
      dcnt       <= '0;
      pending    <= '0;
      slow_clk_d <= 1'b0;
    end else begin
      state      <= state_n;
      cur_floor  <= floor_n;
      dir_up     <= dir_n;
      tcnt       <= tcnt_n;
      dcnt       <= dcnt_n;
      pending    <= pend_n;
      slow_clk_d <= slow_clk;
    end
  end

  assign moving    = (state == MOVE);
  assign door_open = (state == DOOR);

endmodule

// File: tb/tb_lift_car_ctrl.sv
// tb_lift_car_ctrl: directed scenarios for lift_car_ctrl with a 50:1
// slow clock; expected output snapshots go through a scoreboard queue.
module tb_lift_car_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       slow_clk;
  logic [3:0] call_req = '0;
  logic [1:0] cur_floor;
  logic       dir_up, moving, door_open;
  logic [3:0] pending;

  lift_car_ctrl #(
    .FLOORS(4),
    .TRAVEL_TICKS(2),
    .DOOR_TICKS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .slow_clk(slow_clk),
    .call_req(call_req),
    .cur_floor(cur_floor),
    .dir_up(dir_up),
    .moving(moving),
    .door_open(door_open),
    .pending(pending)
  );

  always #5 clk = ~clk;

  // Upstream 50:1 divider model
  int div_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= 0;
      slow_clk <= 1'b0;
    end else if (div_cnt == 24) begin
      div_cnt  <= 0;
      slow_clk <= ~slow_clk;
    end else begin
      div_cnt <= div_cnt + 1;
    end
  end

  // Independent tick counter
  logic sd;
  int   tick_no = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) sd <= 1'b0;
    else       sd <= slow_clk;
  end
  always @(posedge clk) begin
    if (!reset && slow_clk && !sd) tick_no <= tick_no + 1;
  end

  typedef struct packed {
    logic [1:0] fl;
    logic       up;
    logic       mv;
    logic       dr;
    logic [3:0] pd;
  } snap_t;

  snap_t obs;
  assign obs = {cur_floor, dir_up, moving, door_open, pending};

  snap_t exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    failures = 0;
  int    base;

  task automatic exp_push(input string tag, input logic [1:0] f,
                          input logic u, input logic m,
                          input logic d, input logic [3:0] p);
    snap_t e;
    e = '{fl: f, up: u, mv: m, dr: d, pd: p};
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic sb_check();
    snap_t e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", t, obs, e);
    end
  endtask

  task automatic wait_tick_no(input int t);
    for (int i = 0; i < 1000; i++) begin
      if (tick_no >= t) break;
      @(posedge clk);
      #1;
    end
    if (tick_no < t) begin
      checks++;
      assert (tick_no >= t) else begin
        failures++;
        $error("FAIL tick_wait observed=%0d expected=%0d",
               tick_no, t);
      end
    end
  endtask

  task automatic call(input logic [3:0] m);
    @(negedge clk);
    call_req = m;
    @(negedge clk);
    call_req = '0;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    exp_push("reset_hold", 2'd0, 1, 0, 0, 4'b0000);
    sb_check();
    reset = 1'b0;
    edge1();
    exp_push("reset_release", 2'd0, 1, 0, 0, 4'b0000);
    sb_check();

    // Single call 0 -> 2
    exp_push("s2_latched", 2'd0, 1, 0, 0, 4'b0100);
    call(4'b0100);
    sb_check();
    exp_push("s2_move", 2'd0, 1, 1, 0, 4'b0100);
    edge1();
    sb_check();
    base = tick_no;
    exp_push("s2_tick1", 2'd0, 1, 1, 0, 4'b0100);
    wait_tick_no(base + 1);
    sb_check();
    exp_push("s2_floor1", 2'd1, 1, 1, 0, 4'b0100);
    wait_tick_no(base + 2);
    sb_check();
    exp_push("s2_tick3", 2'd1, 1, 1, 0, 4'b0100);
    wait_tick_no(base + 3);
    sb_check();
    exp_push("s2_arrive2", 2'd2, 1, 0, 1, 4'b0000);
    wait_tick_no(base + 4);
    sb_check();
    base = tick_no;
    exp_push("s2_door_t2", 2'd2, 1, 0, 1, 4'b0000);
    wait_tick_no(base + 2);
    sb_check();
    exp_push("s2_door_close", 2'd2, 1, 0, 0, 4'b0000);
    wait_tick_no(base + 3);
    sb_check();

    // Call at current floor, then again during DOOR
    exp_push("s3_latched", 2'd2, 1, 0, 0, 4'b0100);
    call(4'b0100);
    sb_check();
    exp_push("s3_door", 2'd2, 1, 0, 1, 4'b0000);
    edge1();
    sb_check();
    base = tick_no;
    exp_push("s3_absorbed", 2'd2, 1, 0, 1, 4'b0000);
    call(4'b0100);
    sb_check();
    exp_push("s3_close", 2'd2, 1, 0, 0, 4'b0000);
    wait_tick_no(base + 3);
    sb_check();

    // Reset pulse mid-stream
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_push("s4_async", 2'd0, 1, 0, 0, 4'b0000);
    sb_check();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    edge1();
    exp_push("s4_release", 2'd0, 1, 0, 0, 4'b0000);
    sb_check();

    // Intermediate stop on the way 0 -> 3
    call(4'b1000);
    exp_push("s5_move", 2'd0, 1, 1, 0, 4'b1000);
    edge1();
    sb_check();
    base = tick_no;
    wait_tick_no(base + 1);
    exp_push("s5_add2", 2'd0, 1, 1, 0, 4'b1100);
    call(4'b0100);
    sb_check();
    exp_push("s5_floor1", 2'd1, 1, 1, 0, 4'b1100);
    wait_tick_no(base + 2);
    sb_check();
    exp_push("s5_stop2", 2'd2, 1, 0, 1, 4'b1000);
    wait_tick_no(base + 4);
    sb_check();
    base = tick_no;
    exp_push("s5_idle2", 2'd2, 1, 0, 0, 4'b1000);
    wait_tick_no(base + 3);
    sb_check();
    exp_push("s5_resume", 2'd2, 1, 1, 0, 4'b1000);
    edge1();
    sb_check();
    base = tick_no;
    exp_push("s5_stop3", 2'd3, 1, 0, 1, 4'b0000);
    wait_tick_no(base + 2);
    sb_check();
    base = tick_no;
    wait_tick_no(base + 3);

    // Direction priority: down to 1, then up to 3 with a call at 0
    call(4'b0010);
    exp_push("s6_flip_dn", 2'd3, 0, 1, 0, 4'b0010);
    edge1();
    sb_check();
    base = tick_no;
    exp_push("s6_stop1", 2'd1, 0, 0, 1, 4'b0000);
    wait_tick_no(base + 4);
    sb_check();
    base = tick_no;
    wait_tick_no(base + 3);
    call(4'b1000);
    exp_push("s6_flip_up", 2'd1, 1, 1, 0, 4'b1000);
    edge1();
    sb_check();
    base = tick_no;
    wait_tick_no(base + 1);
    exp_push("s6_add0", 2'd1, 1, 1, 0, 4'b1001);
    call(4'b0001);
    sb_check();
    exp_push("s6_floor2_up", 2'd2, 1, 1, 0, 4'b1001);
    wait_tick_no(base + 2);
    sb_check();
    exp_push("s6_stop3", 2'd3, 1, 0, 1, 4'b0001);
    wait_tick_no(base + 4);
    sb_check();
    base = tick_no;
    exp_push("s6_idle3", 2'd3, 1, 0, 0, 4'b0001);
    wait_tick_no(base + 3);
    sb_check();
    exp_push("s6_rev", 2'd3, 0, 1, 0, 4'b0001);
    edge1();
    sb_check();
    base = tick_no;
    exp_push("s6_floor2_dn", 2'd2, 0, 1, 0, 4'b0001);
    wait_tick_no(base + 2);
    sb_check();

    // Reset mid-move with calls outstanding
    exp_push("s7_pre", 2'd2, 0, 1, 0, 4'b1001);
    call(4'b1000);
    sb_check();
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_push("s7_async", 2'd0, 1, 0, 0, 4'b0000);
    sb_check();
    repeat (3) @(negedge clk);
    exp_push("s7_hold", 2'd0, 1, 0, 0, 4'b0000);
    sb_check();
    reset = 1'b0;
    edge1();
    base = tick_no;
    exp_push("s7_still", 2'd0, 1, 0, 0, 4'b0000);
    wait_tick_no(base + 3);
    sb_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
